// File: rtl/banner_renderer.sv
// Banner bitmap renderer: scaled, positioned, optionally inverted/blinking
// bitmap overlay with a fixed two-stage registered pixel pipeline.
module banner_renderer #(
   parameter int COORD_W      = 10,
   parameter int TILES        = 3,
   parameter int GLYPH_W      = 16,
   parameter int ROWS         = 16,
   parameter int SCALE_LOG2_W = 2,
   parameter int BLINK_BITS   = 5,
   localparam int RW = TILES * GLYPH_W,
   localparam int RB = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int TW = (TILES > 1) ? $clog2(TILES) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [COORD_W-1:0]      px,
   input  logic [COORD_W-1:0]      py,
   input  logic [COORD_W-1:0]      x0,
   input  logic [COORD_W-1:0]      y0,
   input  logic [SCALE_LOG2_W-1:0] scale,
   input  logic                    enable,
   input  logic                    invert,
   input  logic                    blink_en,
   input  logic                    frame_tick,
   input  logic                    wr_en,
   input  logic [RB-1:0]           wr_row,
   input  logic [RW-1:0]           wr_data,
   output logic                    pixel_on,
   output logic                    in_box,
   output logic [TW-1:0]           tile_idx
);

   localparam int AW = COORD_W + SCALE_LOG2_W + 6;
   localparam int CW = (RW > 1) ? $clog2(RW) : 1;

   logic [ROWS-1:0][RW-1:0] bitmap;
   logic [BLINK_BITS-1:0]   fc;

   logic [AW-1:0] pxw, pyw, x0w, y0w, xend, yend;
   logic          inside_d;
   logic [CW-1:0] col_d;
   logic [RB-1:0] row_d;

   logic          inside_q;
   logic [CW-1:0] col_q;
   logic [RB-1:0] row_q;

   logic [RW-1:0] row_bits;
   logic [CW-1:0] bit_idx;
   logic          pix_bit;
   logic          visible;

   // Widened arithmetic so a box running past the coordinate range clips instead of wrapping.
   always_comb begin
      pxw      = AW'(px);
      pyw      = AW'(py);
      x0w      = AW'(x0);
      y0w      = AW'(y0);
      xend     = x0w + (AW'(RW) << scale);
      yend     = y0w + (AW'(ROWS) << scale);
      inside_d = (pxw >= x0w) && (pxw < xend) && (pyw >= y0w) && (pyw < yend);
      col_d    = CW'((pxw - x0w) >> scale);
      row_d    = RB'((pyw - y0w) >> scale);
   end

   always_comb begin
      row_bits = bitmap[row_q];
      bit_idx  = CW'(RW - 1) - col_q;
      pix_bit  = row_bits[bit_idx];
      visible  = enable & (~blink_en | ~fc[BLINK_BITS-1]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bitmap <= '0;
         fc     <= '0;
      end else begin
         if (wr_en)
            bitmap[wr_row] <= wr_data;
         if (frame_tick)
            fc <= fc + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inside_q <= 1'b0;
         col_q    <= '0;
         row_q    <= '0;
         pixel_on <= 1'b0;
         in_box   <= 1'b0;
         tile_idx <= '0;
      end else begin
         inside_q <= inside_d;
         col_q    <= col_d;
         row_q    <= row_d;
         pixel_on <= inside_q & visible & (pix_bit ^ invert);
         in_box   <= inside_q & enable;
         tile_idx <= inside_q ? TW'(col_q / GLYPH_W) : '0;
      end
   end

endmodule

// File: tb/tb_banner_renderer.sv
// Directed scoreboard bench for banner_renderer: expected outputs queued at
// stimulus time, compared two edges later.
module tb_banner_renderer;

   localparam int RW = 48;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  px, py, x0, y0;
   logic [1:0]  scale;
   logic        enable, invert, blink_en, frame_tick, wr_en;
   logic [3:0]  wr_row;
   logic [47:0] wr_data;
   logic        pixel_on, in_box;
   logic [1:0]  tile_idx;

   banner_renderer #(
      .COORD_W(10), .TILES(3), .GLYPH_W(16), .ROWS(16),
      .SCALE_LOG2_W(2), .BLINK_BITS(5)
   ) dut (
      .clk(clk), .reset(reset), .px(px), .py(py), .x0(x0), .y0(y0),
      .scale(scale), .enable(enable), .invert(invert), .blink_en(blink_en),
      .frame_tick(frame_tick), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
      .pixel_on(pixel_on), .in_box(in_box), .tile_idx(tile_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] v;
      string      tag;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   logic        chk = 1'b0;
   logic        vld1 = 1'b0;
   logic        vld2 = 1'b0;
   logic [47:0] mbm[16];
   int          mfc = 0;
   string       tag = "";

   // Reference: {pixel_on, in_box, tile_idx} from plain integer geometry.
   function automatic logic [3:0] model(int x, int y);
      int w, h, col, row, fcv;
      logic ins, b, vis;
      logic [1:0] t;
      logic [47:0] rv;
      w   = RW << scale;
      h   = 16 << scale;
      ins = (x >= int'(x0)) && (x < int'(x0) + w) && (y >= int'(y0)) && (y < int'(y0) + h);
      b   = 1'b0;
      t   = 2'd0;
      if (ins) begin
         col = (x - int'(x0)) >> scale;
         row = (y - int'(y0)) >> scale;
         rv  = mbm[row];
         b   = rv[RW - 1 - col];
         t   = 2'(col / 16);
      end
      fcv = mfc % 32;
      vis = enable && (!blink_en || fcv < 16);
      return {ins & vis & (b ^ invert), ins & enable, t};
   endfunction

   task automatic pix(input int x, input int y, input bit tick = 1'b0,
                      input bit w = 1'b0, input int wrow = 0, input logic [47:0] wd = '0);
      exp_t e;
      @(negedge clk);
      frame_tick = tick;
      if (tick) mfc = (mfc + 1) % 32;
      wr_en   = w;
      wr_row  = 4'(wrow);
      wr_data = wd;
      if (w) mbm[wrow] = wd;
      px  = 10'(x);
      py  = 10'(y);
      chk = 1'b1;
      e.v   = model(x, y);
      e.tag = tag;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         chk = 1'b0;
         frame_tick = 1'b0;
         wr_en = 1'b0;
      end
   endtask

   task automatic wr(input int r, input logic [47:0] d);
      @(negedge clk);
      chk = 1'b0;
      frame_tick = 1'b0;
      wr_en   = 1'b1;
      wr_row  = 4'(r);
      wr_data = d;
      mbm[r]  = d;
   endtask

   always @(posedge clk) begin
      vld2 <= vld1;
      vld1 <= chk;
   end

   always @(posedge clk) begin
      #1;
      if (vld2) begin
         exp_t e;
         total++;
         if (q.size() == 0) begin
            bad++;
            $error("FAIL underflow got=%b required=queued entry", {pixel_on, in_box, tile_idx});
         end else begin
            e = q.pop_front();
            assert ({pixel_on, in_box, tile_idx} === e.v) else begin
               bad++;
               $error("FAIL %s px=%0d py=%0d got=%b required=%b", e.tag, px, py,
                      {pixel_on, in_box, tile_idx}, e.v);
            end
         end
      end
   end

   initial begin
      px = '0; py = '0; x0 = '0; y0 = '0; scale = '0;
      enable = 1'b0; invert = 1'b0; blink_en = 1'b0; frame_tick = 1'b0;
      wr_en = 1'b0; wr_row = '0; wr_data = '0;
      for (int i = 0; i < 16; i++) mbm[i] = '0;

      repeat (2) @(negedge clk);
      total++;
      assert ({pixel_on, in_box, tile_idx} === 4'b0) else begin
         bad++;
         $error("FAIL rst_hold got=%b required=0000", {pixel_on, in_box, tile_idx});
      end
      reset = 1'b0;
      idle(2);

      // Asynchronous reset landing on a pending write must leave the bitmap clear.
      wr(5, '1);
      @(negedge clk);
      wr_en = 1'b1; wr_row = 4'd0; wr_data = '1;
      #2 reset = 1'b1;
      for (int i = 0; i < 16; i++) mbm[i] = '0;
      mfc = 0;
      @(negedge clk);
      wr_en = 1'b0;
      total++;
      assert ({pixel_on, in_box, tile_idx} === 4'b0) else begin
         bad++;
         $error("FAIL rst_async got=%b required=0000", {pixel_on, in_box, tile_idx});
      end
      reset = 1'b0;

      enable = 1'b1;
      tag = "rst_scan";
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 64; x++)
            pix(x, y);
      idle(3);

      tag = "bit_order";
      wr(1, 48'h8000_0000_0001);
      x0 = 10'd100; y0 = 10'd20;
      pix(100, 21); pix(147, 21); pix(101, 21); pix(148, 21);
      pix(99, 21); pix(116, 21); pix(132, 21); pix(100, 36);
      idle(3);

      tag = "scale";
      wr(0, 48'h8000_0000_0000);
      x0 = '0; y0 = '0; scale = 2'd2;
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            pix(x, y);
      pix(191, 63); pix(192, 63); pix(191, 64); pix(64, 10);
      idle(3);

      tag = "clip";
      scale = 2'd3; x0 = 10'd1000; y0 = 10'd1000;
      pix(1023, 1023); pix(1000, 1000); pix(999, 1010);
      idle(3);

      tag = "invert";
      for (int r = 0; r < 16; r++) wr(r, '0);
      scale = '0; x0 = 10'd10; y0 = 10'd10; invert = 1'b1;
      pix(10, 10); pix(57, 25); pix(58, 25); pix(9, 10); pix(30, 26); pix(30, 9);
      idle(3);
      tag = "disable";
      enable = 1'b0;
      pix(10, 10); pix(30, 20); pix(100, 100);
      idle(3);

      tag = "blink";
      enable = 1'b1; invert = 1'b0; blink_en = 1'b1;
      x0 = 10'd100; y0 = 10'd20;
      wr(1, 48'h8000_0000_0001);
      for (int t = 0; t < 36; t++) pix(100, 21, 1'b1);
      idle(3);

      tag = "collision";
      blink_en = 1'b0; x0 = '0; y0 = '0;
      pix(5, 3);
      pix(6, 3, 1'b0, 1'b1, 3, '1);
      pix(7, 3);
      idle(3);
      tag = "last_write";
      wr(4, 48'hAAAA_AAAA_AAAA);
      wr(4, 48'h5555_5555_5555);
      pix(0, 4); pix(1, 4); pix(47, 4);
      idle(4);

      total++;
      assert (q.size() == 0) else begin
         bad++;
         $error("FAIL drain got=%0d required=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/banner_renderer.md
Name: banner_renderer

Overview:
- Parametrised successor to the fixed dot-mask text blocks.
- Holds a writable banner bitmap: ROWS rows, each TILES×GLYPH_W pixels wide.
- Renders the bitmap at a programmable screen origin, with integer upscaling, inversion and frame-synchronous blinking.
- Sits between the display timing generator's pixel counters and the video mixer. Output is registered, with fixed 2-cycle latency.

Parameters:
- COORD_W, 10: width of the pixel coordinate and origin buses.
- TILES, 3: number of 16-pixel tiles per row. Row width is RW = TILES*GLYPH_W.
- GLYPH_W, 16: pixels per tile.
- ROWS, 16: bitmap rows. Must be a power of two.
- SCALE_LOG2_W, 2: width of the scale input. The scale factor is 2^scale.
- BLINK_BITS, 5: width of the frame counter. Blink period is 2^BLINK_BITS frames.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- px  in  COORD_W  current pixel x.
- py  in  COORD_W  current pixel y.
- x0  in  COORD_W  banner left edge.
- y0  in  COORD_W  banner top edge.
- scale  in  SCALE_LOG2_W  log2 of the upscale factor.
- enable  in  1  banner visible.
- invert  in  1  invert pixels inside the box.
- blink_en  in  1  gate visibility with the blink phase.
- frame_tick  in  1  one-cycle pulse per frame.
- wr_en  in  1  bitmap row write strobe.
- wr_row  in  log2(ROWS)  row to write.
- wr_data  in  RW  row data. MSB is the leftmost pixel.
- pixel_on  out  1  pixel lit.
- in_box  out  1  pixel lies inside the scaled banner box.
- tile_idx  out  log2(TILES) (min 1)  tile containing the pixel. 0 is the leftmost tile.

Behaviour:
- Reset (asynchronous):
  - Bitmap cleared to all zero.
  - Frame counter = 0.
  - All pipeline registers = 0.
  - pixel_on = 0, in_box = 0, tile_idx = 0.
  - Outputs stay 0 until 2 edges after reset deassertion.
- Box test, computed in COORD_W+SCALE_LOG2_W+6-bit unsigned arithmetic so there is no wrap:
  - inside iff px >= x0, px < x0 + (RW << scale), py >= y0, and py < y0 + (ROWS << scale).
  - A box extending past the coordinate range is clipped, not wrapped.
- Stage 1 (edge 1): register the inside flag, col = (px - x0) >> scale, and row = (py - y0) >> scale. col and row are don't-care when outside.
- Stage 2 (edge 2):
  - bit = bitmap[row][RW-1-col].
  - visible = enable & (~blink_en | ~fc[BLINK_BITS-1]).
  - pixel_on = inside & visible & (bit ^ invert).
  - in_box = inside & enable.
  - tile_idx = col / GLYPH_W when inside, else 0.
- Latency: outputs reflect the px/py/x0/y0/scale sampled 2 edges earlier. enable, invert and blink_en are sampled at stage 2.
- Frame counter fc:
  - Increments by 1 on each clk edge where frame_tick = 1.
  - Wraps from 2^BLINK_BITS-1 to 0.
  - frame_tick held high for several cycles counts once per cycle.
- Bitmap write:
  - wr_en = 1 writes wr_data into row wr_row on that edge.
  - A write is independent of pipeline flow.
  - A stage-2 read of the same row on the same edge returns the old data. The new data is visible from the next edge.
  - Consecutive writes to the same row: last write wins.
- Mid-frame parameter change: x0, y0 and scale take effect on the pixel sampled at that edge. No shadowing.
- Reset mid-write: the write is discarded and the bitmap is cleared.

Test Plan:
- Reset clears state: reset=1, then release; scan px 0..63, py 0..15 with x0=y0=0, scale=0, enable=1 -> pixel_on=0 everywhere, and in_box=1 only for px<48, py<16.
- Bit order and latency: write row 1 = 48'h8000_0000_0001; set x0=100, y0=20, px=100, py=21 -> pixel_on=1 exactly 2 cycles later. At px=147, pixel_on=1. At px=101, pixel_on=0. At px=148, in_box=0. tile_idx reads 0 at px=100 and 2 at px=147.
- Scaling: scale=2, row 0 = MSB-only, x0=y0=0 -> pixel_on=1 for px 0..3, py 0..3. Box ends at px=191, py=63. px=192 gives in_box=0.
- Invert and enable: invert=1 with an all-zero bitmap -> pixel_on=1 across the whole box and 0 outside. enable=0 -> pixel_on=0 and in_box=0.
- Blink: blink_en=1, BLINK_BITS=5, lit pixel -> visible for frame_ticks 0..15, dark for 16..31, visible again after the 32nd tick (wrap).
- Write/read collision: read row 3 on the same edge that writes row 3 from 0 to all ones -> the old value 0 is output. The next pixel in row 3 outputs 1.
